fetch_unit: RTL

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues one outstanding request at a time to instruction memory using a req/ready request handshake and an rvalid response. Returned instructions go into a one-entry output buffer, which drives ir/pc_IF into IF/ID. The stage honours the IF/ID stall (hazard) and control-flow redirects (flush with target).

---
 rtl/fetch_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, keeps one imem request in flight, buffers one instruction for IF/ID.
// Optional FETCH_PERF_CNT_EN adds buffer-load and bubble-cycle counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] pc_IF,
  output logic        if_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;

  logic [1:0]  state;
  logic [31:0] fetch_pc;
  logic [31:0] pend_pc;
  logic        consume;
  logic        buf_load;

  // if_valid is the buffer-valid flag itself
  assign consume   = if_valid & ~stall;
  assign imem_addr = fetch_pc;
  assign imem_req  = (state == FETCH) & ~redirect & (~if_valid | consume);
  assign buf_load  = (state == WAIT) & imem_rvalid & ~redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      pend_pc  <= RESET_PC;
      if_valid <= 1'b0;
      ir       <= NOP_INSTR;
      pc_IF    <= 32'h0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~32'h3;
      if_valid <= 1'b0;
      ir       <= NOP_INSTR;
      // An in-flight response must still be absorbed before a new request.
      case (state)
        WAIT:    state <= imem_rvalid ? FETCH : DROP;
        DROP:    state <= imem_rvalid ? FETCH : DROP;
        default: state <= FETCH;
      endcase
    end else begin
      if (consume) begin
        if_valid <= 1'b0;
        ir       <= NOP_INSTR;
      end
      case (state)
        FETCH: begin
          if (imem_req && imem_ready) begin
            pend_pc  <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if_valid <= 1'b1;
            ir       <= imem_rdata;
            pc_IF    <= pend_pc;
            state    <= FETCH;
          end
        end
        DROP: begin
          if (imem_rvalid) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt  <= 32'h0;
      perf_bubble_cnt <= 32'h0;
    end else begin
      if (buf_load) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (!stall && !if_valid) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule
